// File: rtl/pixel_row_output_buffer.sv
// Two-bank ping-pong row buffer: accepts whole rows and streams them out one pixel
// per handshake, with frame markers and a sticky dropped-load flag.
module pixel_row_output_buffer #(
   parameter int WIDTH     = 2,
   parameter int HEIGHT    = 2,
   parameter int BIT_DEPTH = 8,
   localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
   localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
   input  logic                       SYSTEM_CLK,
   input  logic                       SYSTEM_RESET_N,
   input  logic                       ROW_LOAD,
   input  logic [WIDTH*BIT_DEPTH-1:0] ROW_DATA,
   input  logic [RW-1:0]              ROW_INDEX,
   output logic                       BUFFER_READY,
   output logic [BIT_DEPTH-1:0]       PIXEL_DATA,
   output logic                       PIXEL_VALID,
   input  logic                       PIXEL_READY,
   output logic [CW-1:0]              PIXEL_COLUMN,
   output logic [RW-1:0]              PIXEL_ROW,
   output logic                       FRAME_START,
   output logic                       FRAME_END,
   output logic                       LOAD_ERROR,
   input  logic                       ERROR_CLEAR
);

   localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

   logic [WIDTH*BIT_DEPTH-1:0] bank_data_r [2];
   logic [RW-1:0]              bank_row_r  [2];
   logic                       wr_ptr_r;
   logic                       rd_ptr_r;
   logic [1:0]                 count_r;
   logic [CW-1:0]              col_r;
   logic                       load_error_r;

   logic                       space_s;
   logic                       load_ok_s;
   logic                       drop_s;
   logic                       valid_s;
   logic                       fire_s;
   logic                       last_s;
   logic [WIDTH*BIT_DEPTH-1:0] sel_row_s;
   logic [BIT_DEPTH-1:0]       pixel_s;

   // Handshake and load-acceptance decode, all from registered state
   always_comb begin
      space_s   = (count_r < 2'd2);
      load_ok_s = ROW_LOAD && space_s;
      drop_s    = ROW_LOAD && !space_s;
      valid_s   = (count_r != 2'd0);
      fire_s    = valid_s && PIXEL_READY;
      last_s    = fire_s && (col_r == LAST_COL);
   end

   // Pick the current column's pixel out of the read bank
   always_comb begin
      sel_row_s = bank_data_r[rd_ptr_r];
      pixel_s   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pixel_s = (col_r == CW'(i)) ? sel_row_s[i*BIT_DEPTH +: BIT_DEPTH] : pixel_s;
      end
   end

   // Bank storage is not reset; it is masked whenever nothing is buffered
   always_ff @(posedge SYSTEM_CLK) begin
      if (load_ok_s) begin
         bank_data_r[wr_ptr_r] <= ROW_DATA;
         bank_row_r[wr_ptr_r]  <= ROW_INDEX;
      end
   end

   // Pointers, occupancy, column counter and sticky error flag
   always_ff @(posedge SYSTEM_CLK or negedge SYSTEM_RESET_N) begin
      if (!SYSTEM_RESET_N) begin
         wr_ptr_r     <= 1'b0;
         rd_ptr_r     <= 1'b0;
         count_r      <= 2'd0;
         col_r        <= '0;
         load_error_r <= 1'b0;
      end else begin
         if (load_ok_s) begin
            wr_ptr_r <= ~wr_ptr_r;
         end
         if (last_s) begin
            rd_ptr_r <= ~rd_ptr_r;
            col_r    <= '0;
         end else if (fire_s) begin
            col_r <= col_r + CW'(1);
         end
         case ({load_ok_s, last_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
         // A drop in the same cycle as a clear keeps the flag set
         if (drop_s) begin
            load_error_r <= 1'b1;
         end else if (ERROR_CLEAR) begin
            load_error_r <= 1'b0;
         end
      end
   end

   // Output drive; data and row are masked to zero when no pixel is valid
   always_comb begin
      BUFFER_READY = SYSTEM_RESET_N && space_s;
      PIXEL_VALID  = valid_s;
      PIXEL_COLUMN = col_r;
      PIXEL_DATA   = valid_s ? pixel_s : '0;
      PIXEL_ROW    = valid_s ? bank_row_r[rd_ptr_r] : '0;
      FRAME_START  = valid_s && (col_r == '0) && (PIXEL_ROW == '0);
      FRAME_END    = valid_s && (col_r == LAST_COL) && (PIXEL_ROW == LAST_ROW);
      LOAD_ERROR   = load_error_r;
   end

endmodule

// File: doc/pixel_row_output_buffer.md
PIXEL_ROW_OUTPUT_BUFFER -- requirements
Module: pixel_row_output_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 2, pixels per row.
REQ-002 SHALL have parameter HEIGHT, default 2, rows per frame.
REQ-003 SHALL have parameter BIT_DEPTH, default 8, bits per pixel.
REQ-004 SHALL use CW = max(1, clog2(WIDTH)) and RW = max(1, clog2(HEIGHT)) as column and row index widths.
REQ-005 SYSTEM_CLK  in  1  sole clock; all state updates on rising edge.
REQ-006 SYSTEM_RESET_N  in  1  reset; asynchronous and active-low.
REQ-007 ROW_LOAD  in  1  one-cycle strobe; ROW_DATA and ROW_INDEX valid this cycle.
REQ-008 ROW_DATA  in  WIDTH*BIT_DEPTH  row pixels; pixel 0 in bits [BIT_DEPTH-1:0].
REQ-009 ROW_INDEX  in  RW  row number of the loaded row.
REQ-010 BUFFER_READY  out  1  high when a load this cycle will be accepted.
REQ-011 PIXEL_DATA  out  BIT_DEPTH  current output pixel.
REQ-012 PIXEL_VALID  out  1  PIXEL_DATA/PIXEL_COLUMN/PIXEL_ROW valid.
REQ-013 PIXEL_READY  in  1  downstream accepts the pixel when high with PIXEL_VALID.
REQ-014 PIXEL_COLUMN  out  CW  column of current pixel.
REQ-015 PIXEL_ROW  out  RW  row of current pixel.
REQ-016 FRAME_START  out  1  high with the column-0 pixel of row 0.
REQ-017 FRAME_END  out  1  high with the column-(WIDTH-1) pixel of row HEIGHT-1.
REQ-018 LOAD_ERROR  out  1  sticky flag: a load was dropped.
REQ-019 ERROR_CLEAR  in  1  synchronous clear of LOAD_ERROR.

Function
REQ-020 SHALL hold two row banks (ping-pong) with a write pointer, read pointer and occupancy count 0..2.
REQ-021 BUFFER_READY SHALL equal (count < 2), derived from registered state only, not from PIXEL_READY.
REQ-022 ROW_LOAD with BUFFER_READY high SHALL capture ROW_DATA/ROW_INDEX into the write bank, toggle the write pointer, and increment count.
REQ-023 ROW_LOAD with BUFFER_READY low SHALL be dropped, leave all banks unchanged and set LOAD_ERROR, even if a bank frees in the same cycle.
REQ-024 PIXEL_VALID SHALL be high whenever count > 0; first pixel of a load into an empty buffer appears one cycle after the ROW_LOAD edge.
REQ-025 PIXEL_DATA SHALL be pixel PIXEL_COLUMN of the read bank; PIXEL_ROW SHALL be that bank's stored ROW_INDEX.
REQ-026 While PIXEL_VALID high and PIXEL_READY low, all pixel outputs SHALL hold stable.
REQ-027 On handshake (VALID and READY), column SHALL increment; at column WIDTH-1 it SHALL wrap to 0, toggle the read pointer and decrement count.
REQ-028 Simultaneous accepted load and last-pixel handshake SHALL leave count unchanged and move both pointers.
REQ-029 FRAME_START and FRAME_END SHALL be combinational from PIXEL_VALID, PIXEL_COLUMN, PIXEL_ROW; both high together when WIDTH=1 and HEIGHT=1.
REQ-030 ERROR_CLEAR SHALL clear LOAD_ERROR; a dropped load in the same cycle SHALL win (flag stays set).
REQ-031 ROW_INDEX values >= HEIGHT SHALL be stored and output unmodified; FRAME_END then never asserts for that row.

Reset
REQ-032 SYSTEM_RESET_N low SHALL immediately force count=0, both pointers=0, column=0, LOAD_ERROR=0.
REQ-033 During reset: BUFFER_READY=1 only after deassertion, PIXEL_VALID=0, PIXEL_DATA=0, PIXEL_COLUMN=0, PIXEL_ROW=0, FRAME_START=0, FRAME_END=0, LOAD_ERROR=0.
REQ-034 Reset mid-row SHALL discard buffered pixels; first post-reset output SHALL come only from a new load.
REQ-035 Bank contents need not be reset; they SHALL never be visible while PIXEL_VALID is low.

Verification
REQ-036 WIDTH=2, load row 0 = {0x22,0x11}, READY=1 -> next cycle PIXEL_DATA=0x11 col 0 FRAME_START=1, then 0x22 col 1, then VALID=0.
REQ-037 READY=0 for 3 cycles after load -> PIXEL_DATA=0x11, col 0 held; BUFFER_READY=1 (count=1).
REQ-038 Three loads back-to-back, READY=0 -> first two accepted, BUFFER_READY=0 after second, third dropped, LOAD_ERROR=1; ERROR_CLEAR -> 0.
REQ-039 count=2, load coincident with last-pixel handshake -> load dropped, LOAD_ERROR=1, count=1 afterwards.
REQ-040 Load rows 0,1 (HEIGHT=2), READY=1 -> 4 pixels in order, FRAME_END=1 only on row 1 col 1.
REQ-041 Reset asserted after col 0 of a row accepted -> all outputs 0 asynchronously; after release VALID stays 0 until next load.
